// File: rtl/niu_sii_pkg.sv
// Shared types and helpers for the NIU->SII DMA request issuer: FSM states,
// header field offsets, beat/parity widths and the per-16-bit parity function.
package niu_sii_pkg;

  localparam int BEAT_W  = 128;
  localparam int PAR_W   = 8;
  localparam int BE_W    = 16;
  localparam int TAG_W   = 16;
  localparam int PA_W    = 40;
  localparam int TAG_LSB = 64;
  localparam int PA_MSB  = 39;
  localparam int CNT_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PL0,
    ST_PL1,
    ST_PL2,
    ST_PL3
  } state_t;

  // parity[i] covers data[16i+15:16i]
  function automatic logic [PAR_W-1:0] par16(input logic [BEAT_W-1:0] data);
    logic [PAR_W-1:0] p;
    for (int i = 0; i < PAR_W; i++) p[i] = ^data[16*i +: 16];
    return p;
  endfunction

endpackage

// File: rtl/niu_sii_credit_ctr.sv
// Credit counter for one SII inbound queue: starts full at INIT, takes one
// credit per issued request, returns one per dequeue, never exceeds INIT.
module niu_sii_credit_ctr
  import niu_sii_pkg::*;
#(
  parameter int INIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             avail,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);

  // A return at full credit is dropped and latched as a sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= INIT_V;
      ovf <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (cnt == INIT_V) ovf <= 1'b1;
          else               cnt <= cnt + CNT_W'(1);
        end
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign avail = (cnt != '0);

endmodule

// File: rtl/niu_sii_dma_req_issuer.sv
// NIU->SII inbound DMA request issuer: header + 0/1/4 payload beats with parity,
// credit-gated per target queue. Optional macro NIU_SII_PAR_ERR_INJ_EN adds inj_par_err.
module niu_sii_dma_req_issuer
  import niu_sii_pkg::*;
#(
  parameter int OQ_CREDITS = 16,
  parameter int BQ_CREDITS = 16
) (
  input  logic                iol2clk,
  input  logic                rst,
`ifdef NIU_SII_PAR_ERR_INJ_EN
  input  logic                inj_par_err,
`endif
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                req_wr,
  input  logic                req_len16,
  input  logic                req_bypass,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic [PA_W-1:0]     req_pa,
  input  logic [4*BEAT_W-1:0] req_data,
  input  logic [4*BE_W-1:0]   req_be,
  input  logic                sii_niu_oqdq,
  input  logic                sii_niu_bqdq,
  output logic                niu_sii_hdr_vld,
  output logic                niu_sii_reqbypass,
  output logic                niu_sii_datareq,
  output logic                niu_sii_datareq16,
  output logic [BEAT_W-1:0]   niu_sii_data,
  output logic [PAR_W-1:0]    niu_sii_parity,
  output logic [BE_W-1:0]     niu_sii_be
);

  // Handshake: a request transfers on a rising edge where req_vld && req_rdy.
  // req_rdy is combinational on req_bypass so each queue is gated independently.

  state_t state, state_nxt;

  logic                cur_wr, cur_len16, cur_inj;
  logic [4*BEAT_W-1:0] cur_data;
  logic [4*BE_W-1:0]   cur_be;

  logic             oq_avail, bq_avail, oq_ovf, bq_ovf;
  logic [CNT_W-1:0] oq_cnt, bq_cnt;
  logic             credit_ovf;
  logic             can_take, accept, inj_req;

  logic              hdr_nxt, byp_nxt, dr_nxt, dr16_nxt, inj_nxt;
  logic [BEAT_W-1:0] data_nxt;
  logic [BE_W-1:0]   be_nxt;
  logic [PAR_W-1:0]  par_nxt;
  logic              dbg_unused;

`ifdef NIU_SII_PAR_ERR_INJ_EN
  assign inj_req = inj_par_err;
`else
  assign inj_req = 1'b0;
`endif

  // The last cycle of a transfer may overlap the next accept.
  assign can_take = (state == ST_IDLE) ||
                    (state == ST_HDR && !cur_wr) ||
                    (state == ST_PL0 && cur_len16) ||
                    (state == ST_PL3);
  assign req_rdy  = !rst && can_take && (req_bypass ? bq_avail : oq_avail);
  assign accept   = req_vld && req_rdy;

  niu_sii_credit_ctr #(.INIT(OQ_CREDITS)) u_oq_ctr (
    .clk   (iol2clk),
    .rst   (rst),
    .inc   (sii_niu_oqdq),
    .dec   (accept && !req_bypass),
    .cnt   (oq_cnt),
    .avail (oq_avail),
    .ovf   (oq_ovf)
  );

  niu_sii_credit_ctr #(.INIT(BQ_CREDITS)) u_bq_ctr (
    .clk   (iol2clk),
    .rst   (rst),
    .inc   (sii_niu_bqdq),
    .dec   (accept && req_bypass),
    .cnt   (bq_cnt),
    .avail (bq_avail),
    .ovf   (bq_ovf)
  );

  assign credit_ovf = oq_ovf || bq_ovf;
  // Observation-only state kept visible for debug probes.
  assign dbg_unused = ^{credit_ovf, oq_cnt, bq_cnt};

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_HDR;
      ST_HDR:  state_nxt = cur_wr ? ST_PL0 : (accept ? ST_HDR : ST_IDLE);
      ST_PL0:  state_nxt = !cur_len16 ? ST_PL1 : (accept ? ST_HDR : ST_IDLE);
      ST_PL1:  state_nxt = ST_PL2;
      ST_PL2:  state_nxt = ST_PL3;
      ST_PL3:  state_nxt = accept ? ST_HDR : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next-cycle output word; HDR is only ever entered through an accept.
  always_comb begin
    hdr_nxt  = 1'b0;
    byp_nxt  = 1'b0;
    dr_nxt   = 1'b0;
    dr16_nxt = 1'b0;
    inj_nxt  = 1'b0;
    data_nxt = '0;
    be_nxt   = '0;
    unique case (state_nxt)
      ST_HDR: begin
        hdr_nxt                        = 1'b1;
        byp_nxt                        = req_bypass;
        dr_nxt                         = req_wr;
        dr16_nxt                       = req_wr && req_len16;
        data_nxt[TAG_LSB +: TAG_W]     = req_tag;
        data_nxt[PA_MSB:0]             = req_pa;
        inj_nxt                        = inj_req;
      end
      ST_PL0: begin
        data_nxt = cur_data[0 +: BEAT_W];
        be_nxt   = cur_be[0 +: BE_W];
        inj_nxt  = cur_inj;
      end
      ST_PL1: begin
        data_nxt = cur_data[BEAT_W +: BEAT_W];
        be_nxt   = cur_be[BE_W +: BE_W];
        inj_nxt  = cur_inj;
      end
      ST_PL2: begin
        data_nxt = cur_data[2*BEAT_W +: BEAT_W];
        be_nxt   = cur_be[2*BE_W +: BE_W];
        inj_nxt  = cur_inj;
      end
      ST_PL3: begin
        data_nxt = cur_data[3*BEAT_W +: BEAT_W];
        be_nxt   = cur_be[3*BE_W +: BE_W];
        inj_nxt  = cur_inj;
      end
      default: ;
    endcase
    par_nxt = par16(data_nxt) ^ {{(PAR_W-1){1'b0}}, inj_nxt};
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cur_wr            <= 1'b0;
      cur_len16         <= 1'b0;
      cur_inj           <= 1'b0;
      niu_sii_hdr_vld   <= 1'b0;
      niu_sii_reqbypass <= 1'b0;
      niu_sii_datareq   <= 1'b0;
      niu_sii_datareq16 <= 1'b0;
      niu_sii_data      <= '0;
      niu_sii_parity    <= '0;
      niu_sii_be        <= '0;
    end else begin
      state             <= state_nxt;
      niu_sii_hdr_vld   <= hdr_nxt;
      niu_sii_reqbypass <= byp_nxt;
      niu_sii_datareq   <= dr_nxt;
      niu_sii_datareq16 <= dr16_nxt;
      niu_sii_data      <= data_nxt;
      niu_sii_parity    <= par_nxt;
      niu_sii_be        <= be_nxt;
      if (accept) begin
        cur_wr    <= req_wr;
        cur_len16 <= req_len16;
        cur_inj   <= inj_req;
      end
    end
  end

  // Payload holding registers need no reset; they are only read after an accept.
  always_ff @(posedge iol2clk) begin
    if (accept) begin
      cur_data <= req_data;
      cur_be   <= req_be;
    end
  end

endmodule

// File: tb/tb_niu_sii_dma_req_issuer.sv
// Directed bench for niu_sii_dma_req_issuer: table of requests checked by an
// in-order output scoreboard, plus hand-written credit/reset/back-to-back sequences.
module tb_niu_sii_dma_req_issuer;
  import niu_sii_pkg::*;

  logic          iol2clk = 1'b0;
  logic          rst;
  logic          req_vld, req_wr, req_len16, req_bypass;
  logic [15:0]   req_tag;
  logic [39:0]   req_pa;
  logic [511:0]  req_data;
  logic [63:0]   req_be;
  logic          sii_niu_oqdq, sii_niu_bqdq;
`ifdef NIU_SII_PAR_ERR_INJ_EN
  logic          inj_par_err;
`endif

  logic          req_rdy, hdr_vld, reqbypass, datareq, datareq16;
  logic [127:0]  sii_data;
  logic [7:0]    sii_parity;
  logic [15:0]   sii_be;

  logic          d2_rdy, d2_hdr_vld, d2_reqbypass, d2_datareq, d2_datareq16;
  logic [127:0]  d2_data;
  logic [7:0]    d2_parity;
  logic [15:0]   d2_be;

  logic [155:0]  exp_q[$];
  logic [155:0]  out_word;
  int            n_total = 0;
  int            n_bad   = 0;
  logic          mon_en = 1'b0;
  logic          mon_active = 1'b0;

  typedef struct {
    logic        wr;
    logic        len16;
    logic        byp;
    logic [15:0] tag;
    logic [39:0] pa;
    logic [3:0]  exp_flags;
  } vec_t;
  vec_t vecs[6];

  logic [511:0] pat;
  logic [63:0]  be_pat;

  // ---------------- clock / reset ----------------
  always #5 iol2clk = ~iol2clk;

  niu_sii_dma_req_issuer dut (
    .iol2clk(iol2clk), .rst(rst),
`ifdef NIU_SII_PAR_ERR_INJ_EN
    .inj_par_err(inj_par_err),
`endif
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_len16(req_len16),
    .req_bypass(req_bypass), .req_tag(req_tag), .req_pa(req_pa), .req_data(req_data),
    .req_be(req_be), .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq),
    .niu_sii_hdr_vld(hdr_vld), .niu_sii_reqbypass(reqbypass), .niu_sii_datareq(datareq),
    .niu_sii_datareq16(datareq16), .niu_sii_data(sii_data), .niu_sii_parity(sii_parity),
    .niu_sii_be(sii_be)
  );

  niu_sii_dma_req_issuer #(.OQ_CREDITS(2), .BQ_CREDITS(16)) dut2 (
    .iol2clk(iol2clk), .rst(rst),
`ifdef NIU_SII_PAR_ERR_INJ_EN
    .inj_par_err(inj_par_err),
`endif
    .req_vld(req_vld), .req_rdy(d2_rdy), .req_wr(req_wr), .req_len16(req_len16),
    .req_bypass(req_bypass), .req_tag(req_tag), .req_pa(req_pa), .req_data(req_data),
    .req_be(req_be), .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq),
    .niu_sii_hdr_vld(d2_hdr_vld), .niu_sii_reqbypass(d2_reqbypass), .niu_sii_datareq(d2_datareq),
    .niu_sii_datareq16(d2_datareq16), .niu_sii_data(d2_data), .niu_sii_parity(d2_parity),
    .niu_sii_be(d2_be)
  );

  assign out_word = {hdr_vld, reqbypass, datareq, datareq16, sii_be, sii_parity, sii_data};

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Expected word built from first principles: parity per 16-bit lane, bit 0 optionally flipped.
  function automatic logic [155:0] mk(input logic hv, byp, dr, dr16, input logic [15:0] be,
                                      input logic [127:0] data, input logic inj);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^data[16*i +: 16];
    p[0] = p[0] ^ inj;
    return {hv, byp, dr, dr16, be, p, data};
  endfunction

  task automatic push_exp(input logic [3:0] flags, input logic wr, len16,
                          input logic [15:0] tag, input logic [39:0] pa, input logic inj);
    logic [127:0] hd;
    int nb;
    hd = '0;
    hd[79:64] = tag;
    hd[39:0]  = pa;
    exp_q.push_back(mk(flags[3], flags[2], flags[1], flags[0], 16'h0, hd, inj));
    nb = !wr ? 0 : (len16 ? 1 : 4);
    for (int k = 0; k < nb; k++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, be_pat[16*k +: 16], pat[128*k +: 128], inj));
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic wr, len16, byp, input logic [15:0] tag,
                      input logic [39:0] pa, input logic inj);
    int c;
    req_wr = wr; req_len16 = len16; req_bypass = byp; req_tag = tag; req_pa = pa;
    req_data = pat; req_be = be_pat;
`ifdef NIU_SII_PAR_ERR_INJ_EN
    inj_par_err = inj;
`endif
    req_vld = 1'b1;
    c = 0;
    #1;
    while (!req_rdy && c < 40) begin
      tick();
      #1;
      c++;
    end
    if (!req_rdy) begin
      check("rdy_timeout", 256'(req_rdy), 256'(1));
      req_vld = 1'b0;
    end else begin
      tick();
      req_vld = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 30) begin
      tick();
      c++;
    end
    check(name, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = 1'b0;
    sii_niu_oqdq = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    mon_active = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Once the first expected word appears, every following cycle must match in order.
  always @(posedge iol2clk) begin
    #1;
    if (mon_en && (mon_active || out_word != '0)) begin
      if (exp_q.size() == 0) begin
        if (out_word != '0) check("unexpected_out", 256'(out_word), 256'(0));
        mon_active = 1'b0;
      end else begin
        check("out_word", 256'(out_word), 256'(exp_q.pop_front()));
        mon_active = (exp_q.size() != 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [15:0] h;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h1234, 40'h12_3456_7800, 4'b1000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h00A5, 40'h00_0000_1000, 4'b1110};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 40'hFF_FFFF_FFFF, 4'b1011};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 40'h00_0000_0040, 4'b1100};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h8001, 40'h01_2345_6789, 4'b1010};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0F0F, 40'h80_0000_0000, 4'b1111};
    for (int k = 0; k < 4; k++) begin
      h = 16'hA0A0 + 16'(k);
      pat[128*k +: 128] = {8{h}};
    end
    be_pat = 64'hFFFF_0F0F_00FF_8001;

    rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_len16 = 1'b0; req_bypass = 1'b0;
    req_tag = '0; req_pa = '0; req_data = '0; req_be = '0;
    sii_niu_oqdq = 1'b0; sii_niu_bqdq = 1'b0;
`ifdef NIU_SII_PAR_ERR_INJ_EN
    inj_par_err = 1'b0;
`endif
    tick();
    tick();
    check("rst_out", 256'(out_word), 256'(0));
    check("rst_rdy", 256'(req_rdy), 256'(0));
    check("rst_oq", 256'(dut.oq_cnt), 256'(16));
    check("rst_bq", 256'(dut.bq_cnt), 256'(16));
    check("rst_state", 256'(dut.state), 256'(ST_IDLE));
    rst = 1'b0;
    mon_en = 1'b1;

    // table-driven requests
    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i].exp_flags, vecs[i].wr, vecs[i].len16, vecs[i].tag, vecs[i].pa, 1'b0);
      send(vecs[i].wr, vecs[i].len16, vecs[i].byp, vecs[i].tag, vecs[i].pa, 1'b0);
      drain("vec_drain");
      if (i == 0) check("vec0_oq15", 256'(dut.oq_cnt), 256'(15));
    end
    check("vec_oq13", 256'(dut.oq_cnt), 256'(13));
    check("vec_bq13", 256'(dut.bq_cnt), 256'(13));

    // three reads back-to-back, then a write accepted during the last read header
    do_reset();
    push_exp(4'b1000, 1'b0, 1'b0, 16'h0001, 40'h00_0000_0100, 1'b0);
    push_exp(4'b1000, 1'b0, 1'b0, 16'h0002, 40'h00_0000_0200, 1'b0);
    push_exp(4'b1000, 1'b0, 1'b0, 16'h0003, 40'h00_0000_0300, 1'b0);
    push_exp(4'b1010, 1'b1, 1'b0, 16'h0004, 40'h00_0000_0400, 1'b0);
    send(1'b0, 1'b0, 1'b0, 16'h0001, 40'h00_0000_0100, 1'b0);
    send(1'b0, 1'b0, 1'b0, 16'h0002, 40'h00_0000_0200, 1'b0);
    send(1'b0, 1'b0, 1'b0, 16'h0003, 40'h00_0000_0300, 1'b0);
    send(1'b1, 1'b0, 1'b0, 16'h0004, 40'h00_0000_0400, 1'b0);
    drain("b2b_drain");

    // OQ credit exhaustion on the 2-credit instance
    mon_en = 1'b0;
    do_reset();
    req_wr = 1'b0; req_len16 = 1'b0; req_bypass = 1'b0; req_tag = 16'h0055; req_pa = 40'h40;
    req_vld = 1'b1;
    #1 check("t4_rdy1", 256'(d2_rdy), 256'(1));
    tick();
    #1 check("t4_rdy2", 256'(d2_rdy), 256'(1));
    tick();
    #1 check("t4_stall", 256'(d2_rdy), 256'(0));
    check("t4_oq0", 256'(dut2.oq_cnt), 256'(0));
    req_bypass = 1'b1;
    #1 check("t4_byp_rdy", 256'(d2_rdy), 256'(1));
    tick();
    req_bypass = 1'b0;
    #1 check("t4_byp_hdr", 256'({d2_hdr_vld, d2_reqbypass}), 256'(2'b11));
    check("t4_still_stall", 256'(d2_rdy), 256'(0));
    sii_niu_oqdq = 1'b1;
    tick();
    sii_niu_oqdq = 1'b0;
    #1 check("t4_dq_rdy", 256'(d2_rdy), 256'(1));
    tick();
    req_vld = 1'b0;
    #1 check("t4_third_hdr", 256'({d2_hdr_vld, d2_reqbypass, d2_datareq}), 256'(3'b100));
    check("t4_oq_end", 256'(dut2.oq_cnt), 256'(0));
    check("t4_bq_end", 256'(dut2.bq_cnt), 256'(15));

    // simultaneous accept+dq, then overflow at max
    do_reset();
    for (int i = 0; i < 11; i++) send(1'b0, 1'b0, 1'b0, 16'(i), 40'h80, 1'b0);
    check("t5_cnt5", 256'(dut.oq_cnt), 256'(5));
    req_bypass = 1'b0; req_wr = 1'b0; req_vld = 1'b1; sii_niu_oqdq = 1'b1;
    #1 check("t5_rdy", 256'(req_rdy), 256'(1));
    tick();
    req_vld = 1'b0; sii_niu_oqdq = 1'b0;
    check("t5_same", 256'(dut.oq_cnt), 256'(5));
    sii_niu_oqdq = 1'b1;
    repeat (11) tick();
    sii_niu_oqdq = 1'b0;
    check("t5_full", 256'(dut.oq_cnt), 256'(16));
    check("t5_noovf", 256'(dut.credit_ovf), 256'(0));
    sii_niu_oqdq = 1'b1;
    tick();
    sii_niu_oqdq = 1'b0;
    check("t5_capped", 256'(dut.oq_cnt), 256'(16));
    check("t5_ovf", 256'(dut.credit_ovf), 256'(1));
    check("t5_bq", 256'(dut.bq_cnt), 256'(16));

    // reset during PL1 of a 64B write
    do_reset();
    send(1'b1, 1'b0, 1'b1, 16'h0BAD, 40'h00_0000_2000, 1'b0);
    tick();
    tick();
    check("t6_pl1_be", 256'(sii_be), 256'(be_pat[31:16]));
    rst = 1'b1;
    #1 check("t6_rdy_rst", 256'(req_rdy), 256'(0));
    tick();
    check("t6_zero", 256'(out_word), 256'(0));
    check("t6_bq", 256'(dut.bq_cnt), 256'(16));
    check("t6_oq", 256'(dut.oq_cnt), 256'(16));
    check("t6_state", 256'(dut.state), 256'(ST_IDLE));
    rst = 1'b0;
    tick();
    check("t6_idle", 256'(out_word), 256'(0));

`ifdef NIU_SII_PAR_ERR_INJ_EN
    do_reset();
    mon_en = 1'b1;
    push_exp(4'b1010, 1'b1, 1'b0, 16'h0C0C, 40'h00_0000_3000, 1'b1);
    send(1'b1, 1'b0, 1'b0, 16'h0C0C, 40'h00_0000_3000, 1'b1);
    inj_par_err = 1'b0;
    drain("inj_drain");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
